gradient_frame_sequencer: RTL
=============================

# gradient_frame_sequencer

Frame-level controller for the gradient datapath. Manages three frame-memory banks in rotation (write, current, previous). Once a new frame lands, it streams the current/previous frame pair in raster order from the synchronous-read frame memory into `gradient_compute` as `pixel_curr`/`pixel_prev`/`pixel_valid`. It then drains the datapath and signals sequence completion. It sits between the capture writer and `gradient_compute`.

## Interface
- `IMG_WIDTH`, default 320: pixels per line.
- `IMG_HEIGHT`, default 240: lines per frame.
- `PIXEL_WIDTH`, default 8: pixel bits.
- `ADDR_WIDTH`, default 17: frame-memory address bits; must satisfy ≥ clog2(IMG_WIDTH*IMG_HEIGHT).
- `DRAIN_CYCLES`, default 4: idle cycles after the last pixel, to flush the gradient pipeline.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new sequences to start; rotation continues regardless.
- `cap_frame_done`  in  1  single-cycle pulse: capture finished writing bank `wr_bank`.
- `rd_data_curr`  in  PIXEL_WIDTH  memory read data, current bank (1-cycle latency).
- `rd_data_prev`  in  PIXEL_WIDTH  memory read data, previous bank.
- `wr_bank`  out  2  bank capture must write.
- `rd_bank_curr`, `rd_bank_prev`  out  2 each  banks being read.
- `rd_en`  out  1  read strobe to both banks.
- `rd_addr`  out  ADDR_WIDTH  raster read address.
- `pixel_curr`, `pixel_prev`  out  PIXEL_WIDTH  to `gradient_compute`.
- `pixel_valid`  out  1  to `gradient_compute`.
- `frame_start`  out  1  pulse coincident with the first `pixel_valid` of a sequence.
- `frame_end`  out  1  pulse coincident with the last `pixel_valid`.
- `seq_done`  out  1  pulse when drain completes.
- `busy`  out  1  high in STREAM, DRAIN, DONE.
- `drop_count`  out  8  saturating count of frames overwritten before processing.

## Operation
- **States:** IDLE, STREAM, DRAIN, DONE.
- **Bank roles:** always a permutation of {0,1,2}.
- **Rotation** is a single-cycle action: `prev<=curr`, `curr<=wr_bank`, `wr_bank<=old prev`.
- **`frames_valid`** is a 2-bit counter saturating at 2. It increments on each rotation.
- **IDLE, on `cap_frame_done`:**
  - Rotate.
  - If the post-rotation `frames_valid==2` and `enable`, go to STREAM.
  - Otherwise stay in IDLE.
- **STREAM:**
  - `rd_en=1`; `rd_addr` counts 0 to IMG_WIDTH*IMG_HEIGHT-1.
  - After the last address, go to DRAIN.
  - The address counter clears on STREAM entry.
- **DRAIN:** count DRAIN_CYCLES cycles, then go to DONE.
- **DONE (one cycle):** `seq_done=1`.
  - If (`pending` or `cap_frame_done`) and `enable`: rotate, clear `pending`, go to STREAM.
  - If either condition is present but `enable` is low: rotate, clear `pending`, go to IDLE.
  - Else go to IDLE.
- **`cap_frame_done` in STREAM or DRAIN:** no rotation.
  - If `pending` is clear, set it.
  - If `pending` is already set, increment `drop_count` (saturating at 255). The newest data sits in `wr_bank`, which was overwritten.
- **`cap_frame_done` and `pending` both present in DONE:** increment `drop_count` once and rotate once.
- **Output data path:** `pixel_curr`/`pixel_prev` are direct passthrough of `rd_data_*`. `pixel_valid` is `rd_en` registered by one cycle. `frame_start`/`frame_end` are registered alongside `pixel_valid`.
- **Enable gating:** `enable` low does not abort a running sequence. It only blocks starting a new one.

## Timing
- **Reset values:**
  - `wr_bank=0`, `rd_bank_curr=1`, `rd_bank_prev=2`.
  - `rd_addr=0`; `frames_valid=0`; `pending=0`; `drop_count=0`.
  - All strobes and `busy` are 0; state is IDLE.
- **Startup:** `cap_frame_done` sampled at edge T causes rotation visible after T, and `rd_en` high from cycle T+1. First `pixel_valid` and `frame_start` occur at T+2.
- **Stream length:** exactly IMG_WIDTH*IMG_HEIGHT consecutive `rd_en` cycles with no gaps. `pixel_valid` count is identical.
- **DRAIN:** begins the cycle after the last `rd_en`. `seq_done` asserts DRAIN_CYCLES+1 cycles after the last `rd_en`.
- **Back-to-back sequences:** `rd_en` resumes the cycle after DONE.
- **Bank stability:** `rd_bank_*` is stable from STREAM entry through DONE.
- **Reset mid-sequence:** all state returns to reset values immediately. `pixel_valid` deasserts with no further pulses.

## Structure
- **Package `optflow_pkg`:** `seq_state_e` enum, `bank_idx_t` (logic [1:0]), and `NUM_BANKS=3` constant.
- **Sub-module `raster_addr_gen`:** clear/enable counter with a `last` flag.
- **Top-level logic:** FSM, bank rotation, and drop counter live in the top module.

## Test plan
- **Startup:** reset, then two `cap_frame_done` pulses 10 cycles apart.
  - No STREAM after the first pulse; banks become (wr,curr,prev)=(2,0,1).
  - After the second pulse, banks become (1,2,0); 76800 `pixel_valid` cycles follow.
  - `seq_done` fires 5 cycles after the last `rd_en`.
- **Overrun:** inject three `cap_frame_done` pulses during STREAM.
  - `drop_count=2`; exactly one further sequence starts right after DONE.
- **Simultaneous events:** `cap_frame_done` in the DONE cycle with `pending=1`.
  - Single rotation, `drop_count` increments by 1, STREAM resumes next cycle.
- **Enable low:** `enable=0` at the second frame.
  - Rotation occurs; no `rd_en`; state stays IDLE.
  - Raising `enable` alone does not start a sequence; the next `cap_frame_done` does.
- **Reset mid-sequence:** assert `rst` at address 1000.
  - All outputs return to reset values in the same cycle.
  - `frames_valid=0`; two new frames are needed to restart.
- **Data integrity:** memory models return data equal to the address LSBs.
  - `pixel_curr`/`pixel_prev` match `rd_addr` delayed by 1.
  - `frame_start` on address 0 data; `frame_end` on address 76799 data.

Source files
------------

// File: rtl/optflow_pkg.sv
// Shared types for the gradient frame sequencer.
//   seq_state_e : sequencer FSM states
//   bank_idx_t  : frame-memory bank index (0..NUM_BANKS-1)
//   fv_inc      : frames_valid increment, saturating at 2
package optflow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  typedef logic [1:0] bank_idx_t;

  localparam int NUM_BANKS = 3;

  function automatic logic [1:0] fv_inc(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd2 : v + 2'd1;
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster read-address counter for one frame.
//   clk, rst : clock, async active-high reset
//   clr_i    : synchronous clear to address 0 (wins over en_i)
//   en_i     : advance one address; holds on the last address
//   addr_o   : current raster address
//   last_o   : high while addr_o is the final pixel of the frame
module raster_addr_gen #(
  parameter int ADDR_WIDTH = 17,
  parameter int TOTAL      = 76800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q;

  assign last_o = (addr_q == ADDR_WIDTH'(TOTAL - 1));
  assign addr_o = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (clr_i) begin
      addr_q <= '0;
    end else if (en_i && !last_o) begin
      addr_q <= addr_q + 1'b1;
    end
  end

endmodule

// File: rtl/gradient_frame_sequencer.sv
// Frame-level controller for the gradient datapath. Rotates three frame
// banks (write / current / previous), streams the current+previous pair in
// raster order into gradient_compute, drains the pipeline, then pulses
// seq_done.
//   enable           : allow new sequences to start (rotation is unaffected)
//   cap_frame_done   : 1-cycle pulse, capture finished writing wr_bank
//   rd_data_curr/prev: frame memory read data (1-cycle latency)
//   wr_bank, rd_bank_curr, rd_bank_prev : bank roles
//   rd_en, rd_addr   : read strobe and raster address to both banks
//   pixel_curr/prev, pixel_valid, frame_start, frame_end : to gradient_compute
//   seq_done, busy   : sequence status
//   drop_count       : saturating count of frames overwritten unprocessed
//   dbg_state        : FSM state (seq_state_e encoding) for observation
//
// Handshake: there is no backpressure. rd_en is a strobe; the memory answers
// one cycle later, and pixel_valid/frame_start/frame_end are rd_en and its
// first/last-address qualifiers delayed by exactly that one cycle, so they
// line up with the passthrough pixel data.
module gradient_frame_sequencer
  import optflow_pkg::*;
#(
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int PIXEL_WIDTH  = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cap_frame_done,
  input  logic [PIXEL_WIDTH-1:0] rd_data_curr,
  input  logic [PIXEL_WIDTH-1:0] rd_data_prev,
  output logic [1:0]             wr_bank,
  output logic [1:0]             rd_bank_curr,
  output logic [1:0]             rd_bank_prev,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_curr,
  output logic [PIXEL_WIDTH-1:0] pixel_prev,
  output logic                   pixel_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   seq_done,
  output logic                   busy,
  output logic [7:0]             drop_count,
  output logic [1:0]             dbg_state
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e    state_q, state_d;
  bank_idx_t     wr_q, curr_q, prev_q;
  logic [1:0]    fv_q, fv_d;
  logic          pending_q, pending_d;
  logic [7:0]    drop_q, drop_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          pv_q, fs_q, fe_q;

  logic rotate, drop_inc, addr_clr, addr_en, addr_last, rd_en_c, seq_done_c;

  raster_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TOTAL      (TOTAL)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (addr_clr),
    .en_i   (addr_en),
    .addr_o (rd_addr),
    .last_o (addr_last)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    drain_d    = drain_q;
    rotate     = 1'b0;
    drop_inc   = 1'b0;
    addr_clr   = 1'b0;
    addr_en    = 1'b0;
    rd_en_c    = 1'b0;
    seq_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap_frame_done) begin
          rotate = 1'b1;
          if (fv_inc(fv_q) == 2'd2 && enable) begin
            state_d  = ST_STREAM;
            addr_clr = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        rd_en_c = 1'b1;
        addr_en = 1'b1;
        drain_d = '0;
        if (addr_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        seq_done_c = 1'b1;
        state_d    = ST_IDLE;
        // Pending frame and a fresh one together: the pending one is lost,
        // but only one rotation happens so the newest frame becomes current.
        if (pending_q || cap_frame_done) begin
          rotate    = 1'b1;
          pending_d = 1'b0;
          drop_inc  = pending_q && cap_frame_done;
          if (enable) begin
            state_d  = ST_STREAM;
            addr_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Frames arriving mid-sequence: remember one, count any further as dropped.
    if ((state_q == ST_STREAM || state_q == ST_DRAIN) && cap_frame_done) begin
      if (!pending_q) pending_d = 1'b1;
      else            drop_inc  = 1'b1;
    end
    fv_d   = rotate ? fv_inc(fv_q) : fv_q;
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_q      <= 2'd0;
      curr_q    <= 2'd1;
      prev_q    <= 2'd2;
      fv_q      <= 2'd0;
      pending_q <= 1'b0;
      drop_q    <= 8'd0;
      drain_q   <= '0;
      pv_q      <= 1'b0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fv_q      <= fv_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      drain_q   <= drain_d;
      if (rotate) begin
        prev_q <= curr_q;
        curr_q <= wr_q;
        wr_q   <= prev_q;
      end
      pv_q <= rd_en_c;
      fs_q <= rd_en_c && (rd_addr == '0);
      fe_q <= rd_en_c && addr_last;
    end
  end

  assign wr_bank      = wr_q;
  assign rd_bank_curr = curr_q;
  assign rd_bank_prev = prev_q;
  assign rd_en        = rd_en_c;
  assign pixel_curr   = rd_data_curr;
  assign pixel_prev   = rd_data_prev;
  assign pixel_valid  = pv_q;
  assign frame_start  = fs_q;
  assign frame_end    = fe_q;
  assign seq_done     = seq_done_c;
  assign busy         = (state_q != ST_IDLE);
  assign drop_count   = drop_q;
  assign dbg_state    = state_q;

endmodule
